nonce_search_ctrl: RTL and testbench



---
 rtl/nonce_search_ctrl.sv | 125 ++++++++++++
 tb/tb_nonce_search_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nonce_search_ctrl.sv
// rtl/nonce_search_ctrl.sv - sequential nonce search driving a Keccak core
//
// Walks nonces from a start value, hashing {header, nonce} one candidate at
// a time, and stops on the first digest whose top 32 bits are below target
// or after MAX_TRIES completed hashes.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   load, stop          job capture pulse / abort (stop wins over load)
//   header, nonce_in,   job inputs, captured on load
//   target
//   hash_start,         request to the core and its message, held until done
//   hash_msg
//   hash_done, hash_out core completion pulse and digest
//   busy, found,        job status
//   exhausted
//   found_nonce         winning nonce, held until the next load
//   attempts            completed hashes for the current job
`timescale 1ns/1ps
module nonce_search_ctrl #(
    parameter logic [31:0] MAX_TRIES = 32'hFFFF_FFFF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [607:0] header,
    input  logic [31:0]  nonce_in,
    input  logic [31:0]  target,
    input  logic         stop,
    output logic         hash_start,
    output logic [639:0] hash_msg,
    input  logic         hash_done,
    input  logic [255:0] hash_out,
    output logic         busy,
    output logic         found,
    output logic [31:0]  found_nonce,
    output logic         exhausted,
    output logic [31:0]  attempts
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CHECK,
        FOUND,
        EXHAUSTED
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [607:0]  header_q;
    logic [31:0]   nonce_q;
    logic [31:0]   target_q;
    logic [31:0]   digest_top_q;

    logic          win;
    logic          last_try;
    logic          unused_digest_bits;

    // Only the top word of the digest takes part in the comparison.
    assign unused_digest_bits = ^hash_out[223:0];

    assign win      = (digest_top_q < target_q);
    assign last_try = (attempts == MAX_TRIES);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ISSUE:   state_d = WAIT;
            WAIT:    if (hash_done) state_d = CHECK;
            CHECK: begin
                if (win)           state_d = FOUND;
                else if (last_try) state_d = EXHAUSTED;
                else               state_d = ISSUE;
            end
            default: state_d = state_q;
        endcase
        // load restarts from any state; stop overrides everything.
        if (load) state_d = ISSUE;
        if (stop) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            header_q     <= '0;
            nonce_q      <= '0;
            target_q     <= '0;
            digest_top_q <= '0;
            attempts     <= '0;
            found_nonce  <= '0;
        end else begin
            state_q <= state_d;
            // On stop, all job data (including attempts/found_nonce) holds.
            if (!stop) begin
                if (load) begin
                    header_q     <= header;
                    nonce_q      <= nonce_in;
                    target_q     <= target;
                    attempts     <= '0;
                    found_nonce  <= '0;
                end else begin
                    if (state_q == WAIT && hash_done) begin
                        digest_top_q <= hash_out[255:224];
                        attempts     <= attempts + 32'd1;
                    end
                    if (state_q == CHECK) begin
                        if (win)
                            found_nonce <= nonce_q;
                        else if (!last_try)
                            nonce_q <= nonce_q + 32'd1;
                    end
                end
            end
        end
    end

    assign hash_start = (state_q == ISSUE);
    assign hash_msg   = {header_q, nonce_q};
    assign busy       = (state_q == ISSUE) || (state_q == WAIT) || (state_q == CHECK);
    assign found      = (state_q == FOUND);
    assign exhausted  = (state_q == EXHAUSTED);

endmodule

// File: tb/tb_nonce_search_ctrl.sv
// tb/tb_nonce_search_ctrl.sv - self-checking bench for nonce_search_ctrl
`timescale 1ns/1ps
module tb_nonce_search_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         load = 1'b0;
    logic         stop = 1'b0;
    logic [607:0] header = '0;
    logic [31:0]  nonce_in = '0;
    logic [31:0]  target = '0;
    logic         hash_start;
    logic [639:0] hash_msg;
    logic         hash_done = 1'b0;
    logic [255:0] hash_out = '0;
    logic         busy;
    logic         found;
    logic [31:0]  found_nonce;
    logic         exhausted;
    logic [31:0]  attempts;

    int n_assert = 0;
    int n_fail   = 0;

    logic [639:0] exp_q[$];
    logic [31:0]  dig_q[$];
    int           lat = 3;
    int           starts = 0;
    bit           pend = 0;
    int           cnt = 0;
    bit           prev_hs = 0;

    always #5 clk = ~clk;

    nonce_search_ctrl #(.MAX_TRIES(32'd4)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .header(header),
        .nonce_in(nonce_in), .target(target), .stop(stop),
        .hash_start(hash_start), .hash_msg(hash_msg),
        .hash_done(hash_done), .hash_out(hash_out),
        .busy(busy), .found(found), .found_nonce(found_nonce),
        .exhausted(exhausted), .attempts(attempts)
    );

    task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Keccak core model: checks each issued message against the scoreboard,
    // answers after lat cycles with the next queued digest top.
    always @(negedge clk) begin
        logic [31:0] top;
        hash_done = 1'b0;
        if (hash_start) begin
            starts++;
            chk("no_back_to_back_start", prev_hs, 0);
            if (exp_q.size() == 0) chk("unexpected_start", 1, 0);
            else chk("hash_msg", hash_msg, exp_q.pop_front());
            pend = 1;
            cnt  = lat;
        end else if (pend) begin
            if (cnt <= 1) begin
                pend = 0;
                if (dig_q.size() != 0) top = dig_q.pop_front();
                else top = 32'hFFFF_FFFF;
                hash_out  = {top, 224'h0};
                hash_done = 1'b1;
            end else begin
                cnt--;
            end
        end
        prev_hs = hash_start;
    end

    // Returns at the negedge where the first hash_start should be visible.
    task automatic start_job(input logic [607:0] h, input logic [31:0] n, input logic [31:0] t);
        header   = h;
        nonce_in = n;
        target   = t;
        load     = 1'b1;
        @(negedge clk);
        load     = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        for (int i = 0; i < 400 && !(found || exhausted); i++) @(negedge clk);
        chk(tag, found || exhausted, 1);
    endtask

    initial begin
        logic [607:0] h;
        logic [31:0]  s;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_hash_start", hash_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_found", found, 0);
        chk("rst_exhausted", exhausted, 0);
        chk("rst_found_nonce", found_nonce, 0);
        chk("rst_attempts", attempts, 0);
        chk("rst_hash_msg", hash_msg, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Immediate win, slow core
        lat = 24; starts = 0;
        exp_q.push_back({608'h1, 32'h10});
        dig_q.push_back(32'h0000_0001);
        start_job(608'h1, 32'h10, 32'h8000_0000);
        chk("t1_start_latency", hash_start, 1);
        wait_end("t1_timeout");
        chk("t1_found", found, 1);
        chk("t1_exhausted", exhausted, 0);
        chk("t1_found_nonce", found_nonce, 32'h10);
        chk("t1_attempts", attempts, 1);
        chk("t1_starts", starts, 1);

        // Third try wins; equal digest is not a win
        lat = 3; starts = 0;
        h = {19{32'hDEAD_BEEF}};
        s = 32'hA5A5_0000;
        for (int i = 0; i < 3; i++) exp_q.push_back({h, s + 32'(i)});
        dig_q.push_back(32'hFFFF_FFFF);
        dig_q.push_back(32'h0000_1000);
        dig_q.push_back(32'h0000_0FFF);
        start_job(h, s, 32'h0000_1000);
        wait_end("t2_timeout");
        chk("t2_found", found, 1);
        chk("t2_found_nonce", found_nonce, s + 32'd2);
        chk("t2_attempts", attempts, 3);
        chk("t2_starts", starts, 3);
        chk("t2_queue_drained", exp_q.size(), 0);

        // stop from FOUND: flags drop, results hold
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_found_drops", found, 0);
        chk("stop_busy", busy, 0);
        chk("stop_found_nonce_holds", found_nonce, s + 32'd2);
        chk("stop_attempts_hold", attempts, 3);

        // Nonce wrap and exhaustion at MAX_TRIES = 4
        starts = 0;
        h = {19{32'h1234_5678}};
        exp_q.push_back({h, 32'hFFFF_FFFE});
        exp_q.push_back({h, 32'hFFFF_FFFF});
        exp_q.push_back({h, 32'h0000_0000});
        exp_q.push_back({h, 32'h0000_0001});
        for (int i = 0; i < 4; i++) dig_q.push_back(32'hFFFF_FFFF);
        start_job(h, 32'hFFFF_FFFE, 32'h8000_0000);
        wait_end("t3_timeout");
        chk("t3_exhausted", exhausted, 1);
        chk("t3_found", found, 0);
        chk("t3_attempts", attempts, 4);
        chk("t3_found_nonce_cleared", found_nonce, 0);
        chk("t3_starts", starts, 4);
        chk("t3_last_nonce_held", hash_msg[31:0], 32'h1);

        // target 0: even a zero digest cannot win
        starts = 0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({h, 32'h50 + 32'(i)});
            dig_q.push_back(32'h0);
        end
        start_job(h, 32'h50, 32'h0);
        wait_end("t3b_timeout");
        chk("t3b_exhausted", exhausted, 1);
        chk("t3b_found", found, 0);
        chk("t3b_attempts", attempts, 4);

        // stop during WAIT; the late winning digest must be ignored
        lat = 10; starts = 0;
        h = {19{32'hCAFE_0001}};
        exp_q.push_back({h, 32'h700});
        dig_q.push_back(32'h0);
        start_job(h, 32'h700, 32'hFFFF_FFFF);
        repeat (2) @(negedge clk);
        chk("t4a_busy_in_wait", busy, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("t4a_busy_after_stop", busy, 0);
        chk("t4a_no_start", hash_start, 0);
        repeat (15) @(negedge clk);
        chk("t4a_late_done_found", found, 0);
        chk("t4a_late_done_attempts", attempts, 0);
        chk("t4a_late_done_busy", busy, 0);
        chk("t4a_starts", starts, 1);

        // load during WAIT restarts with the new job
        starts = 0;
        exp_q.push_back({h, 32'h800});
        start_job(h, 32'h800, 32'h1);
        repeat (2) @(negedge clk);
        exp_q.push_back({{19{32'hBEEF_0002}}, 32'h900});
        dig_q.push_back(32'h0);
        start_job({19{32'hBEEF_0002}}, 32'h900, 32'h1);
        chk("t4b_restart_start", hash_start, 1);
        chk("t4b_restart_msg", hash_msg, {{19{32'hBEEF_0002}}, 32'h900});
        wait_end("t4b_timeout");
        chk("t4b_found", found, 1);
        chk("t4b_found_nonce", found_nonce, 32'h900);
        chk("t4b_attempts", attempts, 1);
        chk("t4b_starts", starts, 2);

        // Reset while in CHECK
        lat = 2; starts = 0;
        exp_q.push_back({h, 32'hA00});
        dig_q.push_back(32'hFFFF_FFFF);
        start_job(h, 32'hA00, 32'h1);
        repeat (3) @(negedge clk);
        chk("t5_busy_in_check", busy, 1);
        chk("t5_attempts_in_check", attempts, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_hash_start", hash_start, 0);
        chk("t5_rst_found", found, 0);
        chk("t5_rst_exhausted", exhausted, 0);
        chk("t5_rst_found_nonce", found_nonce, 0);
        chk("t5_rst_attempts", attempts, 0);
        chk("t5_rst_hash_msg", hash_msg, 0);
        repeat (10) @(negedge clk);
        chk("t5_no_more_starts", starts, 1);
        chk("t5_idle", busy, 0);

        // load and stop together while busy: stop wins
        lat = 10; starts = 0;
        exp_q.push_back({h, 32'hB00});
        start_job(h, 32'hB00, 32'h1);
        @(negedge clk);
        header = {19{32'h5555_AAAA}};
        nonce_in = 32'hC00;
        load = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        load = 1'b0;
        stop = 1'b0;
        chk("t6_busy", busy, 0);
        chk("t6_no_start", hash_start, 0);
        repeat (15) @(negedge clk);
        chk("t6_starts", starts, 1);
        chk("t6_still_idle", busy, 0);
        chk("t6_attempts", attempts, 0);
        chk("t6_queue_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
